// File: rtl/uart_tx_frame_arbiter_pkg.sv
// Shared types and helpers for the UART frame arbiter: FSM states, header default,
// checksum and stall-counter widths.
package uart_tx_frame_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_WAIT = 3'd4
    } state_t;

    localparam logic [7:0]  HDR_BASE_DEFAULT = 8'hA0;
    localparam int unsigned CSUM_W           = 8;
    localparam int unsigned STALL_W          = 10;

    function automatic logic [CSUM_W-1:0] csum_add(input logic [CSUM_W-1:0] acc,
                                                   input logic [7:0]        b);
        return acc + b;
    endfunction

    // Where a WAIT goes after a payload byte: more payload, trailer, or packet end.
    function automatic state_t after_data(input logic last, input bit csum_en);
        if (!last)
            return ST_DATA;
        else if (csum_en)
            return ST_CSUM;
        else
            return ST_IDLE;
    endfunction

endpackage

// File: rtl/uart_tx_frame_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  grant_id,
    output logic             any_req
);

    logic [ID_W-1:0] hi_id;
    logic [ID_W-1:0] lo_id;
    logic            hi_found;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        hi_id    = '0;
        lo_id    = '0;
        hi_found = 1'b0;
        for (int unsigned i = N_REQ; i > 0; i--) begin
            if (req[i-1]) begin
                lo_id = ID_W'(i - 1);
                if (ID_W'(i - 1) >= ptr) begin
                    hi_id    = ID_W'(i - 1);
                    hi_found = 1'b1;
                end
            end
        end
        grant_id = hi_found ? hi_id : lo_id;
        any_req  = |req;
    end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Shares one async transmitter among N_REQ requesters: whole packets granted round-robin,
// framed as header, payload, optional checksum, with the start/busy handshake sequenced.
module uart_tx_frame_arbiter
    import uart_tx_frame_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned ID_W      = 2,
    parameter logic [7:0]  HDR_BASE  = HDR_BASE_DEFAULT,
    parameter bit          CSUM_EN   = 1'b1,
    parameter int unsigned STALL_MAX = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 abort
);

    state_t              state;
    state_t              ret_state;
    logic                wait_first;
    logic [ID_W-1:0]     rr_ptr;
    logic [CSUM_W-1:0]   csum;
    logic [STALL_W-1:0]  stall_cnt;

    logic [ID_W-1:0]     arb_id;
    logic                any_req;
    logic [ID_W-1:0]     next_ptr;
    logic                stall_hit;
    logic                sel_valid;
    logic                sel_last;
    logic [7:0]          sel_byte;
    logic [N_REQ-1:0]    grant_onehot;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req      (req_valid),
        .ptr      (rr_ptr),
        .grant_id (arb_id),
        .any_req  (any_req)
    );

    always_comb begin
        sel_valid    = 1'b0;
        sel_last     = 1'b0;
        sel_byte     = '0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == grant_id) begin
                sel_valid       = req_valid[i];
                sel_last        = req_last[i];
                sel_byte        = req_data[8*i +: 8];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    assign next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
    assign stall_hit = (stall_cnt == STALL_W'(STALL_MAX - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ret_state  <= ST_IDLE;
            wait_first <= 1'b0;
            rr_ptr     <= '0;
            csum       <= '0;
            stall_cnt  <= '0;
            req_ready  <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            grant_id   <= '0;
            active     <= 1'b0;
            abort      <= 1'b0;
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            abort     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!tx_busy && any_req) begin
                        grant_id  <= arb_id;
                        csum      <= '0;
                        stall_cnt <= '0;
                        active    <= 1'b1;
                        state     <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    tx_start   <= 1'b1;
                    tx_data    <= HDR_BASE | 8'(grant_id);
                    ret_state  <= ST_DATA;
                    wait_first <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_DATA: begin
                    if (sel_valid) begin
                        tx_start   <= 1'b1;
                        tx_data    <= sel_byte;
                        req_ready  <= grant_onehot;
                        csum       <= csum_add(csum, sel_byte);
                        stall_cnt  <= '0;
                        ret_state  <= after_data(sel_last, CSUM_EN);
                        wait_first <= 1'b1;
                        state      <= ST_WAIT;
                    end else if (stall_hit) begin
                        abort     <= 1'b1;
                        active    <= 1'b0;
                        rr_ptr    <= next_ptr;
                        stall_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + STALL_W'(1);
                    end
                end
                ST_CSUM: begin
                    tx_start   <= 1'b1;
                    tx_data    <= csum;
                    ret_state  <= ST_IDLE;
                    wait_first <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Busy rises one clock after start, so the first WAIT cycle cannot trust it.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (!tx_busy) begin
                        state <= ret_state;
                        if (ret_state == ST_IDLE) begin
                            active <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
